// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus bundle between one single-outstanding master and the slave fabric.
interface ahb_lite_master_if;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic        HMASTLOCK;
   logic [3:0]  HPROT;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: one command becomes one 32-bit SINGLE NONSEQ
// transfer; read data and error status come back as a one-cycle response pulse.
module ahb_lite_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   ahb_lite_master_if.master ahb,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [31:0]       cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t      state;
   logic [31:0] haddr_q;
   logic [31:0] hwdata_q;
   logic [31:0] wdata_q;
   logic        hwrite_q;
   logic [1:0]  htrans_q;

   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

`ifndef SYNTHESIS
   // Request registers owned by the bus tasks; they idle at zero so the OR with the port is inert.
   logic        task_valid = 1'b0;
   logic        task_write = 1'b0;
   logic [31:0] task_addr  = '0;
   logic [31:0] task_wdata = '0;

   assign req_valid = cmd_valid | task_valid;
   assign req_write = cmd_write | task_write;
   assign req_addr  = cmd_addr  | task_addr;
   assign req_wdata = cmd_wdata | task_wdata;

   task automatic ahb_issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      @(negedge HCLK);
      while (cmd_ready !== 1'b1) @(negedge HCLK);
      task_valid = 1'b1;
      task_write = wr;
      task_addr  = addr;
      task_wdata = data;
      @(posedge HCLK);
      @(negedge HCLK);
      task_valid = 1'b0;
      task_write = 1'b0;
      task_addr  = '0;
      task_wdata = '0;
      while (rsp_valid !== 1'b1) @(negedge HCLK);
   endtask

   task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
      ahb_issue(1'b1, addr, data);
   endtask

   task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
      ahb_issue(1'b0, addr, '0);
      data = rsp_rdata;
   endtask
`else
   assign req_valid = cmd_valid;
   assign req_write = cmd_write;
   assign req_addr  = cmd_addr;
   assign req_wdata = cmd_wdata;
`endif

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state     <= ST_IDLE;
         haddr_q   <= '0;
         hwdata_q  <= '0;
         wdata_q   <= '0;
         hwrite_q  <= 1'b0;
         htrans_q  <= HTRANS_IDLE;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  haddr_q   <= req_addr & ~32'h3;
                  hwrite_q  <= req_write;
                  wdata_q   <= req_wdata;
                  htrans_q  <= HTRANS_NONSEQ;
                  cmd_ready <= 1'b0;
                  state     <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (ahb.HREADY) begin
                  htrans_q <= HTRANS_IDLE;
                  if (hwrite_q) hwdata_q <= wdata_q;
                  state    <= ST_DATA;
               end
            end
            ST_DATA: begin
               // HRESP=1 with HREADY=0 is the first error cycle; completion waits for HREADY.
               if (ahb.HREADY) begin
                  if (!hwrite_q) rsp_rdata <= ahb.HRDATA;
                  rsp_err   <= ahb.HRESP;
                  rsp_valid <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               htrans_q  <= HTRANS_IDLE;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign ahb.HADDR     = haddr_q;
   assign ahb.HWRITE    = hwrite_q;
   assign ahb.HTRANS    = htrans_q;
   assign ahb.HWDATA    = hwdata_q;
   assign ahb.HBURST    = 3'b000;
   assign ahb.HMASTLOCK = 1'b0;
   assign ahb.HPROT     = HPROT_VAL;
   assign ahb.HSIZE     = 3'b010;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: behavioural AHB-Lite slave with per-transfer wait/error
// programming, plus scoreboards of expected responses and bus transfers.
module tb_ahb_lite_master;

   typedef struct {
      int unsigned waits;
      logic        err;
      logic [31:0] rdata;
   } slv_cfg_t;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int unsigned lat;
   } rsp_exp_t;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_write, cmd_ready;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_cnt = 0;
   int dp_bad  = 0;

   slv_cfg_t slv_q[$];
   bus_t     obs_q[$];
   bus_t     exp_bus_q[$];
   rsp_exp_t exp_q[$];

   bit          slv_auto = 1'b1;
   bit          dp_on    = 1'b0;
   int unsigned dp_left  = 0;
   slv_cfg_t    dp_cfg;
   logic [31:0] dp_addr;
   logic        dp_write;

   ahb_lite_master_if bus ();

   ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .ahb       (bus),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) if (rsp_valid === 1'b1) rsp_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1);
   end

   // Slave decides at each falling edge what it presents at the next rising edge.
   initial begin : slave
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = 32'hDEAD_BEEF;
      forever begin
         @(negedge HCLK);
         if (slv_auto) begin
            if (dp_on) begin
               if (bus.HTRANS !== 2'b00) dp_bad++;
               if (dp_left > 0) begin
                  bus.HREADY = 1'b0;
                  bus.HRESP  = dp_cfg.err && (dp_left == 1);
                  bus.HRDATA = 32'hDEAD_BEEF;
                  dp_left--;
               end else begin
                  bus.HREADY = 1'b1;
                  bus.HRESP  = dp_cfg.err;
                  bus.HRDATA = dp_cfg.rdata;
                  obs_q.push_back('{write: dp_write, addr: dp_addr, wdata: bus.HWDATA});
                  dp_on = 1'b0;
               end
            end else begin
               bus.HREADY = 1'b1;
               bus.HRESP  = 1'b0;
               bus.HRDATA = 32'hDEAD_BEEF;
            end
            if (!dp_on && bus.HTRANS === 2'b10) begin
               dp_addr  = bus.HADDR;
               dp_write = bus.HWRITE;
               if (slv_q.size() > 0) dp_cfg = slv_q.pop_front();
               else dp_cfg = '{waits: 0, err: 1'b0, rdata: 32'hDEAD_0000};
               dp_left = dp_cfg.waits;
               dp_on   = 1'b1;
            end
         end
      end
   end

   task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output bit got, output logic [31:0] rd, output logic e,
                            output int unsigned lat);
      int unsigned n;
      got = 1'b0; rd = 'x; e = 1'bx; lat = 0; n = 0;
      @(negedge HCLK);
      while (cmd_ready !== 1'b1 && n < 20) begin
         @(negedge HCLK);
         n++;
      end
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      @(negedge HCLK);
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      while (lat < 40) begin
         if (rsp_valid === 1'b1) begin
            got = 1'b1; rd = rsp_rdata; e = rsp_err;
            break;
         end
         @(negedge HCLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      n_tests++;
      if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA} !== '0) begin
         n_fail++;
         $display("FAIL reset_bus: HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h, required all zero",
                  bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA);
      end
      n_tests++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, required zero", rsp_valid, rsp_err, rsp_rdata);
      end
      n_tests++;
      if ({bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.HSIZE} !== {3'b000, 1'b0, 4'b0011, 3'b010}) begin
         n_fail++;
         $display("FAIL const_ctrl: HBURST=%b HMASTLOCK=%b HPROT=%b HSIZE=%b, required 000 0 0011 010",
                  bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.HSIZE);
      end
      HRESETn = 1'b1;
      @(negedge HCLK);
      n_tests++;
      if (cmd_ready !== 1'b1 || bus.HTRANS !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle: cmd_ready=%b HTRANS=%b, required 1 00", cmd_ready, bus.HTRANS);
      end
   endtask

   task automatic test_write();
      bus_t ob, eb;
      @(negedge HCLK);
      slv_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h5555_5555});
      exp_bus_q.push_back('{write: 1'b1, addr: 32'hBF40_0008, wdata: 32'h2});
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hBF40_0008; cmd_wdata = 32'h2;
      @(negedge HCLK);
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      n_tests++;
      if ({bus.HTRANS, bus.HWRITE, bus.HADDR, cmd_ready} !== {2'b10, 1'b1, 32'hBF40_0008, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_addr_phase: HTRANS=%b HWRITE=%b HADDR=%h ready=%b, required 10 1 bf400008 0",
                  bus.HTRANS, bus.HWRITE, bus.HADDR, cmd_ready);
      end
      @(negedge HCLK);
      n_tests++;
      if ({bus.HTRANS, bus.HWDATA, rsp_valid} !== {2'b00, 32'h2, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_data_phase: HTRANS=%b HWDATA=%h rsp_valid=%b, required 00 00000002 0",
                  bus.HTRANS, bus.HWDATA, rsp_valid);
      end
      @(negedge HCLK);
      n_tests++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL wr_rsp: valid=%b err=%b rdata=%h, required 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
      end
      @(negedge HCLK);
      n_tests++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_pulse_end: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
      end
      n_tests++;
      eb = exp_bus_q.pop_front();
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL wr_bus: no transfer seen, required write %h<=%h", eb.addr, eb.wdata);
      end else begin
         ob = obs_q.pop_front();
         if (ob.write !== eb.write || ob.addr !== eb.addr || ob.wdata !== eb.wdata) begin
            n_fail++;
            $display("FAIL wr_bus: w=%b %h<=%h, required w=%b %h<=%h", ob.write, ob.addr, ob.wdata,
                     eb.write, eb.addr, eb.wdata);
         end
      end
   endtask

   task automatic test_read_wait();
      bit got; logic [31:0] rd; logic e; int unsigned lat;
      int r0, b0; rsp_exp_t er; bus_t ob, eb;
      slv_q.push_back('{waits: 3, err: 1'b0, rdata: 32'h1});
      exp_q.push_back('{rd: 32'h1, err: 1'b0, lat: 5});
      exp_bus_q.push_back('{write: 1'b0, addr: 32'hBF40_0004, wdata: 32'h0});
      r0 = rsp_cnt; b0 = dp_bad;
      drive_cmd(1'b0, 32'hBF40_0004, 32'h0, got, rd, e, lat);
      er = exp_q.pop_front();
      n_tests++;
      if (!got || rd !== er.rd || e !== er.err || lat != er.lat) begin
         n_fail++;
         $display("FAIL rd_wait_rsp: got=%0d rdata=%h err=%b lat=%0d, required 1 %h %b %0d",
                  got, rd, e, lat, er.rd, er.err, er.lat);
      end
      repeat (3) @(negedge HCLK);
      n_tests++;
      if (rsp_cnt - r0 != 1) begin
         n_fail++;
         $display("FAIL rd_wait_once: %0d pulses, required 1", rsp_cnt - r0);
      end
      n_tests++;
      if (dp_bad != b0 || bus.HWDATA !== 32'h2) begin
         n_fail++;
         $display("FAIL rd_wait_bus: HTRANS busy in data phase %0d times, HWDATA=%h, required 0 00000002",
                  dp_bad - b0, bus.HWDATA);
      end
      n_tests++;
      eb = exp_bus_q.pop_front();
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL rd_wait_bus_xfer: no transfer observed, required read %h", eb.addr);
      end else begin
         ob = obs_q.pop_front();
         if (ob.write !== eb.write || ob.addr !== eb.addr) begin
            n_fail++;
            $display("FAIL rd_wait_bus_xfer: w=%b %h, required w=%b %h", ob.write, ob.addr, eb.write, eb.addr);
         end
      end
   endtask

   task automatic test_error();
      bit got; logic [31:0] rd; logic e; int unsigned lat;
      rsp_exp_t er; bus_t ob, eb;
      slv_q.push_back('{waits: 1, err: 1'b1, rdata: 32'h0BAD_0BAD});
      exp_q.push_back('{rd: 32'h0, err: 1'b1, lat: 3});
      obs_q.delete();
      drive_cmd(1'b0, 32'hBF40_0010, 32'h0, got, rd, e, lat);
      er = exp_q.pop_front();
      n_tests++;
      if (!got || e !== er.err || lat != er.lat) begin
         n_fail++;
         $display("FAIL err_rsp: got=%0d err=%b lat=%0d, required 1 %b %0d", got, e, lat, er.err, er.lat);
      end
      @(negedge HCLK);
      n_tests++;
      if (cmd_ready !== 1'b1 || bus.HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL err_idle: ready=%b HTRANS=%b rsp_valid=%b, required 1 00 0",
                  cmd_ready, bus.HTRANS, rsp_valid);
      end
      obs_q.delete();
      slv_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h3333_3333});
      exp_q.push_back('{rd: 32'h0, err: 1'b0, lat: 2});
      exp_bus_q.push_back('{write: 1'b1, addr: 32'h1234_5674, wdata: 32'hCAFE_F00D});
      drive_cmd(1'b1, 32'h1234_5677, 32'hCAFE_F00D, got, rd, e, lat);
      er = exp_q.pop_front();
      n_tests++;
      if (!got || e !== er.err || lat != er.lat) begin
         n_fail++;
         $display("FAIL err_clear: got=%0d err=%b lat=%0d, required 1 %b %0d", got, e, lat, er.err, er.lat);
      end
      n_tests++;
      eb = exp_bus_q.pop_front();
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL align_bus: no transfer observed, required write %h", eb.addr);
      end else begin
         ob = obs_q.pop_front();
         if (ob.write !== eb.write || ob.addr !== eb.addr || ob.wdata !== eb.wdata) begin
            n_fail++;
            $display("FAIL align_bus: w=%b %h<=%h, required w=%b %h<=%h", ob.write, ob.addr, ob.wdata,
                     eb.write, eb.addr, eb.wdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned n;
      obs_q.delete();
      slv_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h4444_4444});
      slv_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h7777_0001});
      @(negedge HCLK);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0100; cmd_wdata = 32'h1111_1111;
      @(negedge HCLK);
      cmd_write = 1'b0; cmd_addr = 32'h0000_0203; cmd_wdata = '0;
      n_tests++;
      if ({bus.HTRANS, bus.HADDR, cmd_ready} !== {2'b10, 32'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_first: HTRANS=%b HADDR=%h ready=%b, required 10 00000100 0",
                  bus.HTRANS, bus.HADDR, cmd_ready);
      end
      @(negedge HCLK);
      n_tests++;
      if ({bus.HTRANS, bus.HWDATA} !== {2'b00, 32'h1111_1111}) begin
         n_fail++;
         $display("FAIL b2b_busy_ignored: HTRANS=%b HWDATA=%h, required 00 11111111", bus.HTRANS, bus.HWDATA);
      end
      @(negedge HCLK);
      n_tests++;
      if ({rsp_valid, rsp_err, cmd_ready, bus.HTRANS} !== {1'b1, 1'b0, 1'b1, 2'b00}) begin
         n_fail++;
         $display("FAIL b2b_rsp1: valid=%b err=%b ready=%b HTRANS=%b, required 1 0 1 00",
                  rsp_valid, rsp_err, cmd_ready, bus.HTRANS);
      end
      @(negedge HCLK);
      cmd_valid = 1'b0; cmd_addr = '0;
      n_tests++;
      if ({bus.HTRANS, bus.HADDR, bus.HWRITE, rsp_valid} !== {2'b10, 32'h200, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_second: HTRANS=%b HADDR=%h HWRITE=%b rsp_valid=%b, required 10 00000200 0 0",
                  bus.HTRANS, bus.HADDR, bus.HWRITE, rsp_valid);
      end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(negedge HCLK);
         n++;
      end
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h7777_0001 || n != 2) begin
         n_fail++;
         $display("FAIL b2b_rsp2: valid=%b rdata=%h after %0d cycles, required 1 77770001 after 2",
                  rsp_valid, rsp_rdata, n);
      end
      n_tests++;
      if (obs_q.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: %0d transfers, required 2", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_task_poll();
      logic [31:0] d, r;
      int unsigned nreads;
      rsp_exp_t er;
      bus_t ob, eb;
      obs_q.delete();
      nreads = 0;
      do begin
         r = $urandom;
         r[0] = (nreads < 2);
         slv_q.push_back('{waits: nreads, err: 1'b0, rdata: r});
         exp_q.push_back('{rd: r, err: 1'b0, lat: 0});
         exp_bus_q.push_back('{write: 1'b0, addr: 32'hBF40_0004, wdata: 32'h0});
         dut.ahb_read(32'hBF40_0004, d);
         er = exp_q.pop_front();
         n_tests++;
         if (d !== er.rd) begin
            n_fail++;
            $display("FAIL poll_read%0d: %h, required %h", nreads, d, er.rd);
         end
         nreads++;
      end while (d[0] === 1'b1 && nreads < 6);
      n_tests++;
      if (nreads != 3) begin
         n_fail++;
         $display("FAIL poll_count: %0d reads, required 3", nreads);
      end
      slv_q.push_back('{waits: 1, err: 1'b0, rdata: 32'h0});
      exp_bus_q.push_back('{write: 1'b1, addr: 32'hBF40_0000, wdata: 32'hAA});
      dut.ahb_write(32'hBF40_0000, 32'hAA);
      n_tests++;
      if (rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL poll_write_err: %b, required 0", rsp_err);
      end
      while (exp_bus_q.size() > 0) begin
         eb = exp_bus_q.pop_front();
         n_tests++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL poll_bus: no transfer observed, required w=%b %h", eb.write, eb.addr);
         end else begin
            ob = obs_q.pop_front();
            if (ob.write !== eb.write || ob.addr !== eb.addr || (eb.write && ob.wdata !== eb.wdata)) begin
               n_fail++;
               $display("FAIL poll_bus: w=%b %h<=%h, required w=%b %h<=%h", ob.write, ob.addr, ob.wdata,
                        eb.write, eb.addr, eb.wdata);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit got; logic [31:0] rd; logic e; int unsigned lat;
      int r0;
      @(negedge HCLK);
      slv_auto = 1'b0;
      bus.HREADY = 1'b0; bus.HRESP = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0300;
      @(negedge HCLK);
      cmd_valid = 1'b0; cmd_addr = '0;
      @(negedge HCLK);
      n_tests++;
      if ({bus.HTRANS, bus.HADDR} !== {2'b10, 32'h300}) begin
         n_fail++;
         $display("FAIL addr_hold: HTRANS=%b HADDR=%h, required 10 00000300", bus.HTRANS, bus.HADDR);
      end
      r0 = rsp_cnt;
      HRESETn = 1'b0;
      @(negedge HCLK);
      n_tests++;
      if ({bus.HTRANS, bus.HADDR, rsp_valid, cmd_ready} !== {2'b00, 32'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_reset: HTRANS=%b HADDR=%h rsp_valid=%b ready=%b, required 00 00000000 0 1",
                  bus.HTRANS, bus.HADDR, rsp_valid, cmd_ready);
      end
      HRESETn = 1'b1;
      bus.HREADY = 1'b1;
      slv_auto = 1'b1;
      repeat (4) @(negedge HCLK);
      n_tests++;
      if (rsp_cnt != r0) begin
         n_fail++;
         $display("FAIL mid_reset_no_rsp: %0d pulses, required 0", rsp_cnt - r0);
      end
      obs_q.delete();
      slv_q.push_back('{waits: 2, err: 1'b0, rdata: 32'hA5A5_5A5A});
      drive_cmd(1'b0, 32'h0000_0040, 32'h0, got, rd, e, lat);
      n_tests++;
      if (!got || rd !== 32'hA5A5_5A5A || e !== 1'b0 || lat != 4) begin
         n_fail++;
         $display("FAIL mid_reset_recover: got=%0d rdata=%h err=%b lat=%0d, required 1 a5a55a5a 0 4",
                  got, rd, e, lat);
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      HRESETn = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_error();
      test_back_to_back();
      test_task_poll();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
